cordic_phase_gen: RTL and testbench
===================================

# cordic_phase_gen

Phase-accumulator angle source sitting directly upstream of the CORDIC sin/cos computer. It drives the CORDIC angle input with a stream of angles: one per clock, constant frequency, programmable phase offset, optional sample count. Angles use the CORDIC encoding: W-bit two's complement, 2^(W-4) = 45°. Frequency and offset updates arriving mid-burst are deferred to the next phase wrap to keep the output phase-continuous.

## Interface
- W, 20, output angle width; 2^(W-4) = 45°, legal output range [-180°, 180°).
- ACC_W, 32, accumulator width; 2^ACC_W = 360°; must satisfy ACC_W > W.
- CNT_W, 16, sample-counter width.

- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_cfg_valid  in  1  config write strobe.
- io_cfg_ftw  in  ACC_W  frequency tuning word, added per sample, unsigned.
- io_cfg_poff  in  ACC_W  phase offset, added to the accumulator before truncation.
- io_cfg_ready  out  1  config write accepted this cycle when high with valid.
- io_start  in  1  start burst (level sampled per cycle).
- io_stop  in  1  abort burst.
- io_count  in  CNT_W  samples per burst, latched at start; 0 = continuous.
- io_out_a  out  W  angle to CORDIC io_in_a.
- io_out_valid  out  1  io_out_a is a live sample.
- io_busy  out  1  FSM in RUN.
- io_done  out  1  one-cycle pulse with the last sample of a counted burst.

## Operation
- Registers:
  - acc, ftw_act, poff_act (ACC_W each).
  - ftw_pend, poff_pend, pend flag.
  - cnt (CNT_W).
  - FSM state.
- IDLE:
  - Outputs: io_out_valid=0, io_busy=0, io_cfg_ready=1.
  - A config write loads ftw_act and poff_act directly.
  - io_start=1 and io_stop=0: acc←0, cnt←io_count, go to RUN.
- RUN, each cycle:
  - Emit angle = sign-extend(upper W-1 bits of (acc + poff_act) mod 2^ACC_W).
  - acc ← acc + ftw_act (mod 2^ACC_W).
- Counted burst (io_count≠0):
  - cnt decrements per sample.
  - The sample emitted with cnt==1 asserts io_done; the FSM goes to IDLE on that edge.
- Continuous burst (io_count=0): runs until io_stop.
- io_stop in RUN: go to IDLE on that edge. The sample emitted that cycle is still valid; no io_done.
- Config in RUN:
  - io_cfg_ready = !pend.
  - An accepted write goes to ftw_pend/poff_pend and sets pend.
  - On the first edge where acc + ftw_act carries out of ACC_W: ftw_act←ftw_pend, poff_act←poff_pend, pend←0.
  - Writes while pend=1 are ignored.
- Returning to IDLE with pend=1: pending values are applied on the transition edge.
- Simultaneous events:
  - start+stop in IDLE: stay IDLE.
  - start in RUN: ignored.
  - Config write on the same edge as a wrap with pend=0: captured as pending, applied at the following wrap.

## Timing
- Reset values:
  - io_out_a=0, io_out_valid=0, io_busy=0, io_done=0, io_cfg_ready=1.
  - acc, ftw_act, poff_act, cnt = 0.
  - pend=0, state IDLE.
- Outputs are registered.
- io_start sampled at edge k → state RUN after edge k. First valid sample (acc=0, angle = poff truncation) is registered at edge k+1. One sample per cycle follows, no bubbles.
- io_busy is high from edge k to the edge after the last valid sample.
- A counted burst of N gives exactly N consecutive io_out_valid cycles; io_done coincides with the Nth.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronous). Operation resumes only on a new io_start after reset release.
- Truncation rounds toward -∞. No saturation: wrap is modulo 360°.

## Configuration
- CORDIC_PHASE_DITHER_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded 0xACE1 at reset and advances once per valid sample.
  - Its low (ACC_W-W+1) bits are added to (acc + poff_act) before truncation, spreading truncation spurs.
- Not defined: plain truncation, no LFSR logic.

## Test plan
- Reset, ftw=2^26, poff=0, count=4, start → io_out_a = 0, 8192, 16384, 24576 on 4 consecutive cycles; io_done with the 4th; busy low afterwards.
- ftw=2^31, count=3 → angles 0, -262144, 0 (wrap at 180°); no valid outside those 3 cycles.
- poff=2^30 (90°), ftw=0, count=2 → two samples of 131072.
- Continuous run, ftw=2^31; config ftw=2^26 written at the first sample → io_cfg_ready low until the wrap edge; samples 0, -262144, 0, 8192, 16384…
- Continuous run, stop asserted on the 5th sample → exactly 5 valid samples, no io_done; start+stop together in IDLE → no samples.
- Reset driven low mid-burst (async, between edges) → outputs zero immediately; restart gives the first sample = poff truncation. With CORDIC_PHASE_DITHER_EN, run ftw=2^26 and count=8 → each sample differs from the undithered value by at most +1 LSB.

Source files
------------

// File: rtl/cordic_phase_gen_if.sv
// cordic_phase_gen_if: config, burst-control and angle-output signals of the CORDIC phase generator
interface cordic_phase_gen_if #(
    parameter int W     = 20,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
);
    logic             io_cfg_valid;
    logic [ACC_W-1:0] io_cfg_ftw;
    logic [ACC_W-1:0] io_cfg_poff;
    logic             io_cfg_ready;
    logic             io_start;
    logic             io_stop;
    logic [CNT_W-1:0] io_count;
    logic [W-1:0]     io_out_a;
    logic             io_out_valid;
    logic             io_busy;
    logic             io_done;

    modport master (
        output io_cfg_valid, io_cfg_ftw, io_cfg_poff, io_start, io_stop, io_count,
        input  io_cfg_ready, io_out_a, io_out_valid, io_busy, io_done
    );

    modport slave (
        input  io_cfg_valid, io_cfg_ftw, io_cfg_poff, io_start, io_stop, io_count,
        output io_cfg_ready, io_out_a, io_out_valid, io_busy, io_done
    );
endinterface

// File: rtl/cordic_phase_gen.sv
// cordic_phase_gen: phase-accumulator angle source for a CORDIC; define CORDIC_PHASE_DITHER_EN to add LFSR dither before truncation
module cordic_phase_gen #(
    parameter int W     = 20,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input logic clock,
    input logic reset,
    cordic_phase_gen_if.slave io
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam int SH = ACC_W - W + 1;

    logic [0:0]       state;
    logic [ACC_W-1:0] acc, ftw_act, poff_act, ftw_pend, poff_pend, acc_nxt, dith, sum;
    logic [CNT_W-1:0] cnt;
    logic             pend, carry, run, last, leave, cfg_acc;

    assign run             = state == RUN;
    assign io.io_busy      = run;
    assign io.io_cfg_ready = !run || !pend;
    assign cfg_acc         = io.io_cfg_valid && io.io_cfg_ready;
    assign {carry, acc_nxt} = {1'b0, acc} + {1'b0, ftw_act};
    assign last            = cnt == CNT_W'(1);
    assign leave           = run && (io.io_stop || last);
    assign sum             = acc + poff_act + dith;

`ifdef CORDIC_PHASE_DITHER_EN
    logic [15:0] lfsr;

    // Dither LFSR steps once per emitted sample; only sub-LSB bits are used
    always_ff @(posedge clock or negedge reset)
        if (!reset) lfsr <= 16'hACE1;
        else if (run) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    assign dith = ACC_W'(lfsr) & ((ACC_W'(1) << SH) - ACC_W'(1));
`else
    assign dith = '0;
`endif

    // Burst FSM, accumulator and deferred-config bookkeeping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            acc             <= '0;
            ftw_act         <= '0;
            poff_act        <= '0;
            ftw_pend        <= '0;
            poff_pend       <= '0;
            pend            <= 1'b0;
            cnt             <= '0;
            io.io_out_a     <= '0;
            io.io_out_valid <= 1'b0;
            io.io_done      <= 1'b0;
        end else if (!run) begin
            io.io_out_valid <= 1'b0;
            io.io_done      <= 1'b0;
            if (cfg_acc) begin
                ftw_act  <= io.io_cfg_ftw;
                poff_act <= io.io_cfg_poff;
            end
            if (io.io_start && !io.io_stop) begin
                state <= RUN;
                acc   <= '0;
                cnt   <= io.io_count;
            end
        end else begin
            io.io_out_a     <= W'($signed(sum) >>> SH);
            io.io_out_valid <= 1'b1;
            io.io_done      <= last && !io.io_stop;
            acc             <= acc_nxt;
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
            if (leave) begin
                state <= IDLE;
                pend  <= 1'b0;
                if (cfg_acc) begin
                    ftw_act  <= io.io_cfg_ftw;
                    poff_act <= io.io_cfg_poff;
                end else if (pend) begin
                    ftw_act  <= ftw_pend;
                    poff_act <= poff_pend;
                end
            end else if (carry && pend) begin
                ftw_act  <= ftw_pend;
                poff_act <= poff_pend;
                pend     <= 1'b0;
            end else if (cfg_acc) begin
                ftw_pend  <= io.io_cfg_ftw;
                poff_pend <= io.io_cfg_poff;
                pend      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cordic_phase_gen.sv
// tb_cordic_phase_gen: table-driven bursts plus hand sequences for deferred config, stop and async reset
module tb_cordic_phase_gen;
    localparam int W = 20, ACC_W = 32, CNT_W = 16, NV = 7;
`ifdef CORDIC_PHASE_DITHER_EN
    localparam bit DITH = 1'b1;
`else
    localparam bit DITH = 1'b0;
`endif

    typedef struct {
        logic [31:0] ftw;
        logic [31:0] poff;
        int          n;
        int          exp [8];
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0, n_bad = 0;
    int   nv, nd, first;
    int   got [32];
    bit   gd  [32];
    vec_t vt  [NV];

    cordic_phase_gen_if #(.W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) io ();
    cordic_phase_gen #(.W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (.clock(clock), .reset(reset), .io(io));

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_ang(input string nm, input int act, input int exp);
        n_cmp++;
        if (!(act == exp || (DITH && act == exp + 1))) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d%s", nm, act, exp, DITH ? " (or +1)" : "");
        end
    endtask

    task automatic cfg(input logic [31:0] f, input logic [31:0] p);
        io.io_cfg_valid = 1'b1;
        io.io_cfg_ftw   = f;
        io.io_cfg_poff  = p;
        tick();
        io.io_cfg_valid = 1'b0;
    endtask

    task automatic start(input int n);
        io.io_count = CNT_W'(n);
        io.io_start = 1'b1;
        tick();
        io.io_start = 1'b0;
    endtask

    task automatic collect(input int budget);
        nv = 0;
        nd = 0;
        first = -1;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (io.io_done) nd++;
            if (io.io_out_valid) begin
                if (first < 0) first = c;
                if (nv < 32) begin
                    got[nv] = int'($signed(io.io_out_a));
                    gd[nv]  = io.io_done;
                end
                nv++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0] = '{32'h0400_0000, 32'h0, 4, '{0, 8192, 16384, 24576, 0, 0, 0, 0}};
        vt[1] = '{32'h8000_0000, 32'h0, 3, '{0, -262144, 0, 0, 0, 0, 0, 0}};
        vt[2] = '{32'h0, 32'h4000_0000, 2, '{131072, 131072, 0, 0, 0, 0, 0, 0}};
        vt[3] = '{32'h1000_0000, 32'h8000_0000, 3, '{-262144, -229376, -196608, 0, 0, 0, 0, 0}};
        vt[4] = '{32'hFFFF_E000, 32'h0, 3, '{0, -1, -2, 0, 0, 0, 0, 0}};
        vt[5] = '{32'h0000_1000, 32'h0, 4, '{0, 0, 1, 1, 0, 0, 0, 0}};
        vt[6] = '{32'h0400_0000, 32'h0, 8, '{0, 8192, 16384, 24576, 32768, 40960, 49152, 57344}};
        io.io_cfg_valid = 1'b0;
        io.io_cfg_ftw   = '0;
        io.io_cfg_poff  = '0;
        io.io_start     = 1'b0;
        io.io_stop      = 1'b0;
        io.io_count     = '0;

        #12;
        check("reset out_a", io.io_out_a, 0);
        check("reset valid", io.io_out_valid, 0);
        check("reset busy", io.io_busy, 0);
        check("reset done", io.io_done, 0);
        check("reset ready", io.io_cfg_ready, 1);
        @(posedge clock);
        #1 reset = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            cfg(vt[i].ftw, vt[i].poff);
            start(vt[i].n);
            collect(vt[i].n + 4);
            check($sformatf("v%0d count", i), nv, vt[i].n);
            check($sformatf("v%0d latency", i), first, 0);
            check($sformatf("v%0d done count", i), nd, 1);
            for (int j = 0; j < vt[i].n && j < nv; j++) begin
                check_ang($sformatf("v%0d angle[%0d]", i, j), got[j], vt[i].exp[j]);
                check($sformatf("v%0d done[%0d]", i, j), gd[j], j == vt[i].n - 1);
            end
            check($sformatf("v%0d busy after", i), io.io_busy, 0);
        end

        cfg(32'h8000_0000, 32'h0);
        start(0);
        io.io_cfg_valid = 1'b1;
        io.io_cfg_ftw   = 32'h0400_0000;
        io.io_cfg_poff  = 32'h0;
        tick();
        io.io_cfg_valid = 1'b0;
        check_ang("cont s0", int'($signed(io.io_out_a)), 0);
        check("cont ready pending", io.io_cfg_ready, 0);
        tick();
        check_ang("cont s1", int'($signed(io.io_out_a)), -262144);
        check("cont ready after wrap", io.io_cfg_ready, 1);
        tick();
        check_ang("cont s2", int'($signed(io.io_out_a)), 0);
        tick();
        check_ang("cont s3", int'($signed(io.io_out_a)), 8192);
        tick();
        check_ang("cont s4", int'($signed(io.io_out_a)), 16384);
        io.io_stop = 1'b1;
        tick();
        io.io_stop = 1'b0;
        check("cont stop valid", io.io_out_valid, 1);
        check_ang("cont s5", int'($signed(io.io_out_a)), 24576);
        check("cont stop done", io.io_done, 0);
        check("cont stop busy", io.io_busy, 0);
        tick();
        check("cont after stop valid", io.io_out_valid, 0);

        cfg(32'h0400_0000, 32'h0);
        io.io_count = '0;
        io.io_start = 1'b1;
        tick();
        io.io_start = 1'b0;
        nv = 0;
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            io.io_stop = (nv == 4);
            tick();
            if (io.io_out_valid) begin
                nv++;
                got[0] = int'($signed(io.io_out_a));
            end
            if (io.io_done) nd++;
        end
        io.io_stop = 1'b0;
        check("stop5 count", nv, 5);
        check("stop5 done", nd, 0);
        check_ang("stop5 last angle", got[0], 32768);

        io.io_start = 1'b1;
        io.io_stop  = 1'b1;
        tick();
        io.io_start = 1'b0;
        io.io_stop  = 1'b0;
        check("start+stop busy", io.io_busy, 0);
        collect(5);
        check("start+stop samples", nv, 0);

        cfg(32'h0400_0000, 32'h0);
        start(2);
        io.io_cfg_valid = 1'b1;
        io.io_cfg_ftw   = 32'h0800_0000;
        io.io_cfg_poff  = 32'h0;
        tick();
        io.io_cfg_valid = 1'b0;
        collect(3);
        start(2);
        collect(4);
        check("exit-apply count", nv, 2);
        check_ang("exit-apply s0", got[0], 0);
        check_ang("exit-apply s1", got[1], 16384);

        cfg(32'h0400_0000, 32'h2000_0000);
        start(0);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        check("async reset valid", io.io_out_valid, 0);
        check("async reset out_a", io.io_out_a, 0);
        check("async reset busy", io.io_busy, 0);
        check("async reset ready", io.io_cfg_ready, 1);
        collect(3);
        check("held reset samples", nv, 0);
        reset = 1'b1;
        tick();
        collect(3);
        check("post reset idle samples", nv, 0);
        cfg(32'h0400_0000, 32'h2000_0000);
        start(1);
        collect(4);
        check("restart count", nv, 1);
        check_ang("restart first", got[0], 65536);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
